// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK mode encodings and next-state/drive helpers shared by the JK cell and counter
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case (jk_mode_e'({j, k}))
            JK_HOLD:   return q;
            JK_RESET:  return 1'b0;
            JK_SET:    return 1'b1;
            JK_TOGGLE: return ~q;
            default:   return q;
        endcase
    endfunction

    // Set or reset only where the bit differs from the target; matching bits hold.
    function automatic logic [1:0] jk_drive(input logic q, input logic d);
        return {d & ~q, ~d & q};
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// rtl/jk_mod_counter_if.sv - Command/status bundle of the JK modulo counter
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, wrap
    );
endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - Single JK flip-flop with asynchronous active-low clear
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_qbar
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(r_q, i_j, i_k);
        end
    end

    assign o_q    = r_q;
    assign o_qbar = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - Modulo-N up/down counter built from JK cells
// JK_MOD_COUNTER_SAT_EN: saturate at the ends of the range instead of wrapping.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_mod_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULO - 1);
    localparam bit               FULL_RANGE = (MODULO == (1 << WIDTH));

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qbar;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_target;
    logic             w_drive_target;
    logic             w_term;
    logic             r_wrap;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_j    (w_j[gi]),
            .i_k    (w_k[gi]),
            .o_q    (w_q[gi]),
            .o_qbar (w_qbar[gi])
        );
    end

    // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
    always_comb begin
        logic v_carry;
        v_carry  = 1'b1;
        w_toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_toggle[i] = v_carry;
            v_carry     = v_carry & (bus.up ? w_q[i] : w_qbar[i]);
        end
    end

    assign w_term = bus.en & ~bus.load & (bus.up ? (w_q == MAX_VAL) : (w_q == '0));

    always_comb begin
        w_j            = '0;
        w_k            = '0;
        w_target       = '0;
        w_drive_target = 1'b0;
        if (bus.load) begin
            w_drive_target = 1'b1;
            w_target       = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        end else if (bus.en) begin
`ifdef JK_MOD_COUNTER_SAT_EN
            if (!w_term) begin
                w_j = w_toggle;
                w_k = w_toggle;
            end
`else
            // A full-range counter wraps through the toggle rule on its own.
            if (w_term && !FULL_RANGE) begin
                w_drive_target = 1'b1;
                w_target       = bus.up ? '0 : MAX_VAL;
            end else begin
                w_j = w_toggle;
                w_k = w_toggle;
            end
`endif
        end
        if (w_drive_target) begin
            for (int i = 0; i < WIDTH; i++) begin
                {w_j[i], w_k[i]} = jk_drive(w_q[i], w_target[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
`ifdef JK_MOD_COUNTER_SAT_EN
            r_wrap <= 1'b0;
`else
            r_wrap <= w_term;
`endif
        end
    end

    assign bus.count = w_q;
    assign bus.tc    = w_term;
    assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - Self-checking bench for jk_mod_counter against an arithmetic reference model
module tb_jk_mod_counter;

    localparam int WIDTH  = 4;
    localparam int MODULO = 10;

    logic clk;
    logic rst_n;

    jk_mod_counter_if #(.WIDTH(WIDTH)) bus ();

    jk_mod_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_pass;
    int   n_total;
    int   m_count;
    bit   m_wrap;
    bit   exp_tc;
    logic obs_tc;

    // Drives one command, samples tc before the edge, advances the reference model.
    task automatic apply(input bit e, input bit u, input bit l, input int lv);
        int nc;
        bit nw;
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = WIDTH'(lv);
        #1;
        obs_tc = bus.tc;
        exp_tc = e && !l && (u ? (m_count == MODULO - 1) : (m_count == 0));
        nc = m_count;
        nw = 1'b0;
        if (l) begin
            nc = (lv > MODULO - 1) ? MODULO - 1 : lv;
        end else if (e) begin
            if (u && m_count == MODULO - 1) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                nc = m_count;
`else
                nc = 0;
                nw = 1'b1;
`endif
            end else if (!u && m_count == 0) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                nc = m_count;
`else
                nc = MODULO - 1;
                nw = 1'b1;
`endif
            end else begin
                nc = u ? m_count + 1 : m_count - 1;
            end
        end
        @(posedge clk);
        m_count = nc;
        m_wrap  = nw;
        #1;
    endtask

    task automatic pulse_reset;
        bus.en   = 1'b0;
        bus.up   = 1'b0;
        bus.load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset;
        #1;
        rst_n   = 1'b1;
        m_count = 0;
        m_wrap  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_total++;
        if (bus.count !== WIDTH'(0)) $display("FAIL reset_count: got %0d want 0", bus.count);
        else n_pass++;
        n_total++;
        if (bus.wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", bus.wrap);
        else n_pass++;
        apply(0, 0, 1, 6);
        apply(1, 1, 0, 0);
        n_total++;
        if (bus.count !== WIDTH'(7)) $display("FAIL pre_reset_count: got %0d want 7", bus.count);
        else n_pass++;
        pulse_reset();
        n_total++;
        if (bus.count !== WIDTH'(0)) $display("FAIL async_reset_count: got %0d want 0", bus.count);
        else n_pass++;
        release_reset();
        apply(0, 0, 1, 9);
        apply(1, 1, 0, 0);
`ifndef JK_MOD_COUNTER_SAT_EN
        n_total++;
        if (bus.wrap !== 1'b1) $display("FAIL pre_reset_wrap: got %b want 1", bus.wrap);
        else n_pass++;
`endif
        pulse_reset();
        n_total++;
        if (bus.wrap !== 1'b0) $display("FAIL async_reset_wrap: got %b want 0", bus.wrap);
        else n_pass++;
        n_total++;
        if (bus.count !== WIDTH'(0)) $display("FAIL async_reset_count2: got %0d want 0", bus.count);
        else n_pass++;
        release_reset();
    endtask

`ifndef JK_MOD_COUNTER_SAT_EN
    task automatic test_up_wrap;
        apply(0, 0, 1, 0);
        for (int k = 0; k < 10; k++) begin
            apply(1, 1, 0, 0);
            n_total++;
            if (obs_tc !== (k == 9)) $display("FAIL up_tc[%0d]: got %b want %b", k, obs_tc, (k == 9));
            else n_pass++;
            n_total++;
            if (bus.count !== WIDTH'((k + 1) % 10)) $display("FAIL up_count[%0d]: got %0d want %0d", k, bus.count, (k + 1) % 10);
            else n_pass++;
            n_total++;
            if (bus.wrap !== (k == 9)) $display("FAIL up_wrap[%0d]: got %b want %b", k, bus.wrap, (k == 9));
            else n_pass++;
        end
    endtask

    task automatic test_down_wrap;
        int seq [4] = '{1, 0, 9, 8};
        apply(0, 0, 1, 2);
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, 0, 0);
            n_total++;
            if (obs_tc !== (k == 2)) $display("FAIL down_tc[%0d]: got %b want %b", k, obs_tc, (k == 2));
            else n_pass++;
            n_total++;
            if (bus.count !== WIDTH'(seq[k])) $display("FAIL down_count[%0d]: got %0d want %0d", k, bus.count, seq[k]);
            else n_pass++;
            n_total++;
            if (bus.wrap !== (k == 2)) $display("FAIL down_wrap[%0d]: got %b want %b", k, bus.wrap, (k == 2));
            else n_pass++;
        end
    endtask
`endif

    task automatic test_load;
        int lv   [3] = '{5, 9, 13};
        int want [3] = '{5, 9, 9};
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 1, lv[k]);
            n_total++;
            if (obs_tc !== 1'b0) $display("FAIL load_tc[%0d]: got %b want 0", k, obs_tc);
            else n_pass++;
            n_total++;
            if (bus.count !== WIDTH'(want[k])) $display("FAIL load_count[%0d]: got %0d want %0d", k, bus.count, want[k]);
            else n_pass++;
            n_total++;
            if (bus.wrap !== 1'b0) $display("FAIL load_wrap[%0d]: got %b want 0", k, bus.wrap);
            else n_pass++;
        end
    endtask

    task automatic test_hold_dir;
        int seq [4] = '{5, 4, 5, 4};
        apply(0, 0, 1, 4);
        for (int k = 0; k < 3; k++) begin
            apply(0, k[0], 0, 0);
            n_total++;
            if (bus.count !== WIDTH'(4)) $display("FAIL hold_count[%0d]: got %0d want 4", k, bus.count);
            else n_pass++;
            n_total++;
            if (obs_tc !== 1'b0) $display("FAIL hold_tc[%0d]: got %b want 0", k, obs_tc);
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            apply(1, (k % 2) == 0, 0, 0);
            n_total++;
            if (bus.count !== WIDTH'(seq[k])) $display("FAIL dir_count[%0d]: got %0d want %0d", k, bus.count, seq[k]);
            else n_pass++;
        end
    endtask

`ifdef JK_MOD_COUNTER_SAT_EN
    task automatic test_saturate;
        int seq [3] = '{9, 9, 9};
        apply(0, 0, 1, 8);
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 0, 0);
            n_total++;
            if (bus.count !== WIDTH'(seq[k])) $display("FAIL sat_up_count[%0d]: got %0d want %0d", k, bus.count, seq[k]);
            else n_pass++;
            n_total++;
            if (bus.wrap !== 1'b0) $display("FAIL sat_up_wrap[%0d]: got %b want 0", k, bus.wrap);
            else n_pass++;
        end
        apply(0, 0, 1, 1);
        for (int k = 0; k < 2; k++) begin
            apply(1, 0, 0, 0);
            n_total++;
            if (bus.count !== WIDTH'(0)) $display("FAIL sat_down_count[%0d]: got %0d want 0", k, bus.count);
            else n_pass++;
            n_total++;
            if (obs_tc !== (k == 1)) $display("FAIL sat_down_tc[%0d]: got %b want %b", k, obs_tc, (k == 1));
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random;
        for (int k = 0; k < 300; k++) begin
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, (1 << WIDTH) - 1)));
            n_total++;
            if (obs_tc !== exp_tc) $display("FAIL rand_tc[%0d]: got %b want %b", k, obs_tc, exp_tc);
            else n_pass++;
            n_total++;
            if (bus.count !== WIDTH'(m_count)) $display("FAIL rand_count[%0d]: got %0d want %0d", k, bus.count, m_count);
            else n_pass++;
            n_total++;
            if (bus.wrap !== m_wrap) $display("FAIL rand_wrap[%0d]: got %b want %b", k, bus.wrap, m_wrap);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        m_count      = 0;
        m_wrap       = 1'b0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up       = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        #12;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
`ifndef JK_MOD_COUNTER_SAT_EN
        test_up_wrap();
        test_down_wrap();
`else
        test_saturate();
`endif
        test_load();
        test_hold_dir();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
